rle1_enc: RTL and testbench

//   Run-length encoder for a stream of 1-bit symbols. It is the transmit-side

---
 rtl/rle1_enc.sv | 113 +++++++++++
 tb/tb_rle1_enc.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle1_enc.sv
// Run-length encoder: groups equal 1-bit symbols into {symbol, count, last}
// packets, splitting runs at the maximum count.
module rle1_enc #(
    parameter int SYMBOL_WIDTH = 1,
    parameter int COUNT_WIDTH  = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [SYMBOL_WIDTH:0]               rle1__input_r,
    input  logic                                rle1__input_r_vld,
    output logic                                rle1__input_r_rdy,
    output logic [SYMBOL_WIDTH+COUNT_WIDTH:0]   rle1__output_s,
    output logic                                rle1__output_s_vld,
    input  logic                                rle1__output_s_rdy
);

    localparam int OW = SYMBOL_WIDTH + COUNT_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] MAXC = '1;
    localparam logic [COUNT_WIDTH-1:0] ONE  = COUNT_WIDTH'(1);

    logic                    r_run_valid;
    logic [SYMBOL_WIDTH-1:0] r_run_sym;
    logic [COUNT_WIDTH-1:0]  r_run_cnt;
    logic                    r_flush_pending;
    logic [OW-1:0]           r_out_data;
    logic                    r_out_vld;

    logic                    w_run_valid;
    logic [SYMBOL_WIDTH-1:0] w_run_sym;
    logic [COUNT_WIDTH-1:0]  w_run_cnt;
    logic                    w_flush_pending;
    logic [OW-1:0]           w_out_data;
    logic                    w_out_vld;

    logic [SYMBOL_WIDTH-1:0] w_sym;
    logic                    w_last;
    logic                    w_can_load;
    logic                    w_accept;
    logic                    w_flush;

    assign w_sym      = rle1__input_r[SYMBOL_WIDTH:1];
    assign w_last     = rle1__input_r[0];
    assign w_can_load = ~r_out_vld | rle1__output_s_rdy;
    assign w_accept   = ~reset & rle1__input_r_vld & ~r_flush_pending & w_can_load;
    assign w_flush    = r_flush_pending & w_can_load;

    assign rle1__input_r_rdy  = w_accept;
    assign rle1__output_s     = r_out_data;
    assign rle1__output_s_vld = r_out_vld;

    always_comb begin
        w_run_valid     = r_run_valid;
        w_run_sym       = r_run_sym;
        w_run_cnt       = r_run_cnt;
        w_flush_pending = r_flush_pending;
        w_out_data      = r_out_data;
        w_out_vld       = r_out_vld & ~rle1__output_s_rdy;
        unique case (1'b1)
            w_flush: begin
                w_out_data      = {r_run_sym, r_run_cnt, 1'b1};
                w_out_vld       = 1'b1;
                w_run_valid     = 1'b0;
                w_flush_pending = 1'b0;
            end
            w_accept: begin
                if (!r_run_valid) begin
                    w_run_sym   = w_sym;
                    w_run_cnt   = ONE;
                    w_run_valid = ~w_last;
                    if (w_last) begin
                        w_out_data = {w_sym, ONE, 1'b1};
                        w_out_vld  = 1'b1;
                    end
                end else if (w_sym == r_run_sym && r_run_cnt != MAXC) begin
                    w_run_cnt = r_run_cnt + ONE;
                    if (w_last) begin
                        w_out_data  = {w_sym, r_run_cnt + ONE, 1'b1};
                        w_out_vld   = 1'b1;
                        w_run_valid = 1'b0;
                    end
                end else begin
                    // closing packet now; a final beat leaves a second packet for the flush cycle
                    w_out_data      = {r_run_sym, r_run_cnt, 1'b0};
                    w_out_vld       = 1'b1;
                    w_run_sym       = w_sym;
                    w_run_cnt       = ONE;
                    w_flush_pending = w_last;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_valid     <= 1'b0;
            r_run_sym       <= '0;
            r_run_cnt       <= '0;
            r_flush_pending <= 1'b0;
            r_out_data      <= '0;
            r_out_vld       <= 1'b0;
        end else begin
            r_run_valid     <= w_run_valid;
            r_run_sym       <= w_run_sym;
            r_run_cnt       <= w_run_cnt;
            r_flush_pending <= w_flush_pending;
            r_out_data      <= w_out_data;
            r_out_vld       <= w_out_vld;
        end
    end

endmodule

// File: tb/tb_rle1_enc.sv
// Bench for rle1_enc: frame-level run model plus directed timing checks
// and randomized traffic with random backpressure.
module tb_rle1_enc;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in_data;
    logic       in_vld;
    logic       in_rdy;
    logic [5:0] out_data;
    logic       out_vld;
    logic       out_rdy = 1'b1;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;

    bit         fr[$];
    logic [5:0] mq[$];
    logic [5:0] exp_q[$];
    logic [1:0] drv_q[$];

    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic       prst = 1'b1;
    logic [5:0] pd = '0;
    logic [5:0] e;

    always #5 clk = ~clk;

    rle1_enc dut (
        .clk                (clk),
        .reset              (reset),
        .rle1__input_r      (in_data),
        .rle1__input_r_vld  (in_vld),
        .rle1__input_r_rdy  (in_rdy),
        .rle1__output_s     (out_data),
        .rle1__output_s_vld (out_vld),
        .rle1__output_s_rdy (out_rdy)
    );

    function automatic logic [5:0] pkt(bit s, int c, bit l);
        return {s, 4'(c), l};
    endfunction

    // Whole-frame model: maximal runs, each cut into chunks of at most 15.
    function automatic void model_frame();
        int i = 0;
        int j;
        int len;
        int c;
        int n;
        mq.delete();
        n = fr.size();
        while (i < n) begin
            j = i;
            while (j < n && fr[j] == fr[i]) j++;
            len = j - i;
            while (len > 0) begin
                c = (len > 15) ? 15 : len;
                len -= c;
                mq.push_back(pkt(fr[i], c, (len == 0 && j == n)));
            end
            i = j;
        end
    endfunction

    task automatic add_frame(bit drv);
        model_frame();
        foreach (mq[k]) exp_q.push_back(mq[k]);
        if (drv)
            foreach (fr[k]) drv_q.push_back({fr[k], 1'(k == fr.size() - 1)});
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic pin(string nm, logic [5:0] a, logic [5:0] b, int n);
        model_frame();
        checks++;
        if (mq.size() != n || mq[0] !== a || (n > 1 && mq[1] !== b)) begin
            errors++;
            $display("FAIL %s actual_n=%0d first=%0h required_n=%0d first=%0h",
                     nm, mq.size(), (mq.size() > 0) ? mq[0] : 6'h0, n, a);
        end
    endtask

    task automatic beat(logic [1:0] d, logic exp_rdy, string nm);
        @(negedge clk);
        in_vld  = 1'b1;
        in_data = d;
        #1;
        chk(nm, 32'(in_rdy), 32'(exp_rdy));
    endtask

    task automatic idle();
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    task automatic drive_all(int gap);
        int cyc = 0;
        while (drv_q.size() > 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if ($urandom_range(0, 99) < gap) begin
                in_vld = 1'b0;
            end else begin
                in_vld  = 1'b1;
                in_data = drv_q[0];
            end
            #1;
            if (in_rdy) void'(drv_q.pop_front());
        end
        if (drv_q.size() > 0) begin
            errors++;
            $display("FAIL drive_timeout actual=%0d beats_left required=0", drv_q.size());
        end
        idle();
    endtask

    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = ($urandom_range(0, 99) < 70);
            default: out_rdy = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        #4;
        if (!reset) begin
            if (out_vld && out_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_pkt actual=%0h required=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL pkt actual=%0h required=%0h", out_data, e);
                    end
                end
            end
            if (pv && !pr && !prst) begin
                checks++;
                if (!out_vld || out_data !== pd) begin
                    errors++;
                    $display("FAIL hold actual=%0h/%0b required=%0h/1", out_data, out_vld, pd);
                end
            end
            if (out_vld && !out_rdy) begin
                checks++;
                if (in_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_rdy actual=%0b required=0", in_rdy);
                end
            end
        end
        pv   = out_vld;
        pr   = out_rdy;
        pd   = out_data;
        prst = reset;
    end

    initial begin
        int w;
        bit s;
        int len;
        int flip;
        reset   = 1'b1;
        in_vld  = 1'b1;
        in_data = 2'b11;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("reset_vld", 32'(out_vld), 0);
            chk("reset_data", 32'(out_data), 0);
            chk("reset_rdy", 32'(in_rdy), 0);
        end
        @(negedge clk);
        reset  = 1'b0;
        in_vld = 1'b0;

        fr = '{1'b1, 1'b1, 1'b1, 1'b0};
        pin("pin_1110", 6'h26, 6'h03, 2);
        fr = '{1'b0};
        pin("pin_0", 6'h03, 6'h00, 1);
        fr = '{1'b1};
        pin("pin_1", 6'h23, 6'h00, 1);
        fr.delete();
        repeat (17) fr.push_back(1'b1);
        pin("pin_17", 6'h3E, 6'h25, 2);
        fr.delete();
        repeat (16) fr.push_back(1'b1);
        pin("pin_16", 6'h3E, 6'h23, 2);
        fr = '{1'b0, 1'b0, 1'b1};
        pin("pin_001", 6'h04, 6'h23, 2);

        fr = '{1'b0};
        add_frame(0);
        beat(2'b01, 1'b1, "acc_0L");
        idle();
        #1;
        chk("lat_0L_vld", 32'(out_vld), 1);
        chk("lat_0L", 32'(out_data), 32'h03);
        fr = '{1'b1};
        add_frame(0);
        beat(2'b11, 1'b1, "acc_1L");
        idle();
        #1;
        chk("lat_1L", 32'(out_data), 32'h23);
        repeat (2) idle();

        fr = '{1'b1, 1'b1, 1'b1, 1'b0};
        add_frame(0);
        beat(2'b10, 1'b1, "r1110_b0");
        beat(2'b10, 1'b1, "r1110_b1");
        beat(2'b10, 1'b1, "r1110_b2");
        beat(2'b01, 1'b1, "r1110_b3");
        chk("no_pkt_mid_run", 32'(out_vld), 0);
        idle();
        #1;
        chk("r1110_p0", 32'(out_data), 32'h26);
        idle();
        #1;
        chk("r1110_p1", 32'(out_data), 32'h03);
        repeat (2) idle();

        fr = '{1'b0, 1'b0, 1'b1};
        add_frame(0);
        fr = '{1'b1};
        add_frame(0);
        beat(2'b00, 1'b1, "f001_b0");
        beat(2'b00, 1'b1, "f001_b1");
        beat(2'b11, 1'b1, "f001_b2");
        beat(2'b11, 1'b0, "flush_rdy_low");
        chk("f001_p0", 32'(out_data), 32'h04);
        beat(2'b11, 1'b1, "after_flush_rdy");
        chk("f001_p1", 32'(out_data), 32'h23);
        idle();
        #1;
        chk("f001_p2", 32'(out_data), 32'h23);
        repeat (2) idle();

        rdy_mode = 2;
        fr = '{1'b0};
        add_frame(0);
        fr = '{1'b1};
        add_frame(0);
        beat(2'b01, 1'b1, "bp_acc");
        repeat (4) begin
            beat(2'b11, 1'b0, "bp_stall");
            chk("bp_data", 32'(out_data), 32'h03);
        end
        rdy_mode = 0;
        beat(2'b11, 1'b1, "bp_release");
        idle();
        #1;
        chk("bp_next", 32'(out_data), 32'h23);
        repeat (2) idle();

        beat(2'b10, 1'b1, "rst_b0");
        beat(2'b10, 1'b1, "rst_b1");
        @(negedge clk);
        in_vld = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        fr = '{1'b0};
        add_frame(0);
        beat(2'b01, 1'b1, "rst_acc");
        idle();
        #1;
        chk("rst_pkt", 32'(out_data), 32'h03);
        repeat (2) idle();

        rdy_mode = 1;
        for (int f = 0; f < 60; f++) begin
            fr.delete();
            len  = $urandom_range(1, 40);
            flip = (f % 3 == 0) ? 4 : 30;
            s    = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 99) < flip) s = ~s;
                fr.push_back(s);
            end
            add_frame(1);
        end
        drive_all(20);

        rdy_mode = 0;
        w = 0;
        while (exp_q.size() > 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        repeat (5) idle();
        chk("drain", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
